// File: rtl/fib_progress_monitor.sv
// Progress scoreboard behind the Fibonacci write checker: counts in-order F and sum hits and drives a PASS/FAIL verdict.
// Build option: define FIB_MON_STRICT_ORDER_EN to require strictly ascending hit order per stream.
module fib_progress_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned TO_W           = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] F_chk,
   input  logic [5:0] sum_chk,
   output logic       busy,
   output logic       pass,
   output logic       fail,
   output logic [1:0] err_code,
   output logic [2:0] f_count,
   output logic [2:0] sum_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_ORDER = 2'd1;
   localparam logic [1:0] ERR_MULTI = 2'd2;
   localparam logic [1:0] ERR_TIME  = 2'd3;

   function automatic logic [3:0] popcount7(input logic [6:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 7; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   state_t          state_q, state_d;
   logic [6:0]      f_prev_q, f_prev_d;
   logic [5:0]      s_prev_q, s_prev_d;
   logic [6:0]      f_seen_q, f_seen_d;
   logic [5:0]      s_seen_q, s_seen_d;
   logic [2:0]      f_count_q, f_count_d;
   logic [2:0]      sum_count_q, sum_count_d;
   logic [1:0]      err_q, err_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            busy_q, busy_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;

   logic [6:0]      f_hit_s;
   logic [5:0]      s_hit_s;
   logic [3:0]      hit_cnt_s;
   logic            f_ok_s, f_bad_s;
   logic            s_ok_s, s_bad_s;
   logic            done_s;

   // Rising-edge detection so a write held for several cycles counts once.
   always_comb begin
      f_prev_d  = F_chk;
      s_prev_d  = sum_chk;
      f_hit_s   = F_chk & ~f_prev_q;
      s_hit_s   = sum_chk & ~s_prev_q;
      hit_cnt_s = popcount7(f_hit_s) + popcount7({1'b0, s_hit_s});
   end

`ifdef FIB_MON_STRICT_ORDER_EN
   // Strict order: the only acceptable hit is the bit indexed by the current count.
   always_comb begin
      f_ok_s  = (f_hit_s != 7'd0) && (f_hit_s == (7'd1 << f_count_q));
      f_bad_s = (f_hit_s != 7'd0) && !f_ok_s;
      s_ok_s  = (s_hit_s != 6'd0) && (s_hit_s == (6'd1 << sum_count_q));
      s_bad_s = (s_hit_s != 6'd0) && !s_ok_s;
      done_s  = (f_count_d == 3'd7) && (sum_count_d == 3'd6);
   end
`else
   // Relaxed order: any not-yet-seen bit is accepted, re-hits are silently ignored.
   always_comb begin
      f_ok_s  = ((f_hit_s & ~f_seen_q) != 7'd0);
      f_bad_s = 1'b0;
      s_ok_s  = ((s_hit_s & ~s_seen_q) != 6'd0);
      s_bad_s = 1'b0;
      done_s  = (f_seen_d == 7'h7F) && (s_seen_d == 6'h3F);
   end
`endif

   // Next-state, counters, masks and timeout.
   always_comb begin
      state_d     = state_q;
      f_count_d   = f_count_q;
      sum_count_d = sum_count_q;
      err_d       = err_q;
      to_cnt_d    = to_cnt_q;
      f_seen_d    = f_seen_q;
      s_seen_d    = s_seen_q;

      case (state_q)
         ST_RUN: begin
            if (start) begin
               state_d     = ST_RUN;
               f_count_d   = 3'd0;
               sum_count_d = 3'd0;
               err_d       = ERR_NONE;
               to_cnt_d    = '0;
               f_seen_d    = 7'd0;
               s_seen_d    = 6'd0;
            end else if (hit_cnt_s > 4'd1) begin
               state_d = ST_FAIL;
               err_d   = ERR_MULTI;
            end else if (f_bad_s || s_bad_s) begin
               state_d = ST_FAIL;
               err_d   = ERR_ORDER;
            end else if (f_ok_s || s_ok_s) begin
               f_count_d   = f_count_q + {2'b00, f_ok_s};
               sum_count_d = sum_count_q + {2'b00, s_ok_s};
               f_seen_d    = f_seen_q | f_hit_s;
               s_seen_d    = s_seen_q | s_hit_s;
               to_cnt_d    = '0;
               if (done_s) begin
                  state_d = ST_PASS;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (to_cnt_q == TO_LAST) begin
               state_d = ST_FAIL;
               err_d   = ERR_TIME;
            end else begin
               to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
               state_d     = ST_RUN;
               f_count_d   = 3'd0;
               sum_count_d = 3'd0;
               err_d       = ERR_NONE;
               to_cnt_d    = '0;
               f_seen_d    = 7'd0;
               s_seen_d    = 6'd0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      pass_d = (state_d == ST_PASS);
      fail_d = (state_d == ST_FAIL);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         f_prev_q    <= 7'd0;
         s_prev_q    <= 6'd0;
         f_seen_q    <= 7'd0;
         s_seen_q    <= 6'd0;
         f_count_q   <= 3'd0;
         sum_count_q <= 3'd0;
         err_q       <= ERR_NONE;
         to_cnt_q    <= '0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         f_prev_q    <= f_prev_d;
         s_prev_q    <= s_prev_d;
         f_seen_q    <= f_seen_d;
         s_seen_q    <= s_seen_d;
         f_count_q   <= f_count_d;
         sum_count_q <= sum_count_d;
         err_q       <= err_d;
         to_cnt_q    <= to_cnt_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
      end
   end

   assign busy      = busy_q;
   assign pass      = pass_q;
   assign fail      = fail_q;
   assign err_code  = err_q;
   assign f_count   = f_count_q;
   assign sum_count = sum_count_q;

endmodule

// File: tb/tb_fib_progress_monitor.sv
// Directed bench for fib_progress_monitor with a 16-cycle timeout; expectations follow FIB_MON_STRICT_ORDER_EN.
module tb_fib_progress_monitor;

   logic       clk;
   logic       reset;
   logic       start;
   logic [6:0] F_chk;
   logic [5:0] sum_chk;
   logic       busy;
   logic       pass;
   logic       fail;
   logic [1:0] err_code;
   logic [2:0] f_count;
   logic [2:0] sum_count;

   int vectors;
   int miscompares;

   fib_progress_monitor #(
      .TIMEOUT_CYCLES(16),
      .TO_W          (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .F_chk    (F_chk),
      .sum_chk  (sum_chk),
      .busy     (busy),
      .pass     (pass),
      .fail     (fail),
      .err_code (err_code),
      .f_count  (f_count),
      .sum_count(sum_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Snapshot layout: {busy, pass, fail, err[1:0], f_count[2:0], sum_count[2:0]}
   function automatic logic [10:0] snap(input logic b, input logic p, input logic f,
                                        input logic [1:0] e, input logic [2:0] fc,
                                        input logic [2:0] sc);
      return {b, p, f, e, fc, sc};
   endfunction

   task automatic check_vec(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got b/p/f/err/fc/sc=%b/%b/%b/%0d/%0d/%0d expected %b/%b/%b/%0d/%0d/%0d",
                  tag, obs[10], obs[9], obs[8], obs[7:6], obs[5:3], obs[2:0],
                  exp[10], exp[9], exp[8], exp[7:6], exp[5:3], exp[2:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [10:0] dut_snap();
      return snap(busy, pass, fail, err_code, f_count, sum_count);
   endfunction

   initial begin
      int fc;
      int sc;
      vectors     = 0;
      miscompares = 0;
      reset   = 1'b1;
      start   = 1'b0;
      F_chk   = 7'd0;
      sum_chk = 6'd0;
      tick();
      tick();
      reset = 1'b0;
      check_vec("reset", dut_snap(), snap(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));

      // hits while idle are ignored
      F_chk = 7'd1;
      tick();
      F_chk = 7'd0;
      tick();
      check_vec("idle_hit", dut_snap(), snap(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));

      // 1: interleaved full run
      do_start();
      check_vec("t1_start", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));
      fc = 0;
      sc = 0;
      for (int k = 0; k < 13; k++) begin
         if ((k % 2) == 0) begin
            F_chk = 7'd1 << (k / 2);
            fc++;
         end else begin
            sum_chk = 6'd1 << (k / 2);
            sc++;
         end
         tick();
         F_chk   = 7'd0;
         sum_chk = 6'd0;
         if (k == 12) begin
            check_vec("t1_pass", dut_snap(), snap(1'b0, 1'b1, 1'b0, 2'd0, 3'd7, 3'd6));
         end else if (k == 6 || k == 11) begin
            check_vec("t1_mid", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'(fc), 3'(sc)));
         end
         for (int g = 0; g < 3; g++) tick();
      end
      check_vec("t1_hold", dut_snap(), snap(1'b0, 1'b1, 1'b0, 2'd0, 3'd7, 3'd6));

      // 2: held write counts once
      do_start();
      F_chk = 7'd1;
      for (int i = 0; i < 5; i++) tick();
      check_vec("t2_held", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 3'd0));
      F_chk = 7'd2;
      tick();
      F_chk = 7'd0;
      check_vec("t2_second", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 3'd0));

      // 3: out-of-order first hit
      do_start();
      F_chk = 7'd4;
      tick();
      F_chk = 7'd0;
`ifdef FIB_MON_STRICT_ORDER_EN
      check_vec("t3_order", dut_snap(), snap(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 3'd0));
      sum_chk = 6'd1;
      tick();
      sum_chk = 6'd0;
      check_vec("t3_fail_hold", dut_snap(), snap(1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 3'd0));
`else
      check_vec("t3_any", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 3'd0));
      tick();
      F_chk = 7'd4;
      tick();
      F_chk = 7'd0;
      check_vec("t3_rehit", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 3'd0));
`endif

      // 4: two rising bits in one cycle
      do_start();
      F_chk   = 7'd1;
      sum_chk = 6'd1;
      tick();
      F_chk   = 7'd0;
      sum_chk = 6'd0;
      check_vec("t4_multi", dut_snap(), snap(1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 3'd0));

      // 5: timeout exactly 16 edges after start
      do_start();
      for (int i = 0; i < 15; i++) tick();
      check_vec("t5_to_minus1", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));
      tick();
      check_vec("t5_timeout", dut_snap(), snap(1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 3'd0));

      // 5b: hit at edge 10 moves timeout to edge 26
      do_start();
      for (int i = 0; i < 9; i++) tick();
      F_chk = 7'd1;
      tick();
      F_chk = 7'd0;
      for (int i = 0; i < 15; i++) tick();
      check_vec("t5_delay_25", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 3'd0));
      tick();
      check_vec("t5_delay_26", dut_snap(), snap(1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 3'd0));

      // 6: reset mid-run, then start coincident with a hit
      do_start();
      for (int i = 0; i < 3; i++) begin
         F_chk = 7'd1 << i;
         tick();
         F_chk = 7'd0;
         tick();
      end
      check_vec("t6_pre_reset", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd3, 3'd0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_vec("t6_reset", dut_snap(), snap(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));
      do_start();
      F_chk = 7'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      F_chk = 7'd0;
      check_vec("t6_start_hit", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0));
      sum_chk = 6'd1;
      tick();
      sum_chk = 6'd0;
      check_vec("t6_after", dut_snap(), snap(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
